// File: rtl/axi_slv_pkg.sv
// Shared AXI burst/response encodings, FSM state types and address-step helpers
// for the axi_sram_slave block.
package axi_slv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {R_IDLE, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // WRAP and the reserved encoding both advance like INCR; only FIXED holds still.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) begin
      return addr;
    end else begin
      return addr + (32'd1 << size);
    end
  endfunction

  function automatic logic [1:0] burst_resp(input logic [1:0] burst);
    return (burst == 2'b11) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// 1R1W synchronous word array with byte-enable writes and a registered read port.
// A read and write to the same word in one cycle returns the old contents.
module axi_slv_mem #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Byte-lane writes; array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register only loads on a fetch, so it holds the beat while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0000_0000;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM responder with independent read and write FSMs over a byte-writable array.
// Define AXI_SLV_BACKPRESSURE_EN to add LFSR-driven ready/valid stalls.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int ID_W   = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  rd_state_t         rd_state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q, rburst_q;
  logic [31:0]       raddr_q;
  logic [7:0]        rlen_q, rcnt_q;
  logic [2:0]        rsize_q;

  wr_state_t         wr_state_q;
  logic              awready_q, wready_q, bvalid_q, werr_q;
  logic [ID_W-1:0]   awid_q, bid_q;
  logic [1:0]        bresp_q, wburst_q;
  logic [31:0]       waddr_q;
  logic [7:0]        wlen_q, wcnt_q;
  logic [2:0]        wsize_q;

  logic              rd_fire_s, we_s, wbeat_last_s, werr_d;
  logic [MEM_AW-1:0] rd_idx_s, wr_idx_s;
  logic              rdy_ok_s, vld_ok_s;
  logic              unused_s;

  assign unused_s = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot};

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  // Free-running stall pattern generator.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign rdy_ok_s = lfsr_q[0];
  assign vld_ok_s = lfsr_q[1];
`else
  assign rdy_ok_s = 1'b1;
  assign vld_ok_s = 1'b1;
`endif

  // Fetch on AR handshake or when the current beat is consumed and more remain.
  always_comb begin
    rd_fire_s = 1'b0;
    rd_idx_s  = raddr_q[MEM_AW+1:2];
    if (rd_state_q == R_IDLE) begin
      rd_fire_s = arvalid & arready_q;
      rd_idx_s  = araddr[MEM_AW+1:2];
    end else begin
      rd_fire_s = rvalid_q & rready & ~rlast_q;
    end
  end

  assign we_s         = (wr_state_q == W_DATA) & wvalid & wready_q;
  assign wr_idx_s     = waddr_q[MEM_AW+1:2];
  assign wbeat_last_s = (wcnt_q == wlen_q);
  assign werr_d       = werr_q | (wlast ^ wbeat_last_s);

  axi_slv_mem #(.AW(MEM_AW)) u_mem (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .re_i    (rd_fire_s),
    .raddr_i (rd_idx_s),
    .rdata_o (rdata),
    .we_i    (we_s),
    .waddr_i (wr_idx_s),
    .wdata_i (wdata),
    .wstrb_i (wstrb)
  );

  // Read channel FSM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RESP_OKAY;
      raddr_q    <= 32'h0000_0000;
      rlen_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      rburst_q   <= BURST_FIXED;
      rsize_q    <= 3'd0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rd_state_q <= R_BURST;
            arready_q  <= 1'b0;
            rvalid_q   <= vld_ok_s;
            rlast_q    <= (arlen == 8'd0);
            rid_q      <= arid;
            rresp_q    <= burst_resp(arburst);
            raddr_q    <= next_addr(araddr, arsize, arburst);
            rlen_q     <= arlen;
            rcnt_q     <= 8'd0;
            rburst_q   <= arburst;
            rsize_q    <= arsize;
          end else begin
            arready_q <= rdy_ok_s;
          end
        end
        R_BURST: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
          end else if (rready) begin
            if (rlast_q) begin
              rd_state_q <= R_IDLE;
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
            end else begin
              rcnt_q  <= rcnt_q + 8'd1;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
              raddr_q <= next_addr(raddr_q, rsize_q, rburst_q);
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM; burst length comes from awlen, wlast only feeds the error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      werr_q     <= 1'b0;
      awid_q     <= '0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= 32'h0000_0000;
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      wburst_q   <= BURST_FIXED;
      wsize_q    <= 3'd0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (awvalid && awready_q) begin
            wr_state_q <= W_DATA;
            awready_q  <= 1'b0;
            wready_q   <= rdy_ok_s;
            werr_q     <= 1'b0;
            awid_q     <= awid;
            waddr_q    <= awaddr;
            wlen_q     <= awlen;
            wcnt_q     <= 8'd0;
            wburst_q   <= awburst;
            wsize_q    <= awsize;
          end else begin
            awready_q <= rdy_ok_s;
          end
        end
        W_DATA: begin
          if (wvalid && wready_q) begin
            waddr_q <= next_addr(waddr_q, wsize_q, wburst_q);
            if (wbeat_last_s) begin
              wr_state_q <= W_RESP;
              wready_q   <= 1'b0;
              bvalid_q   <= vld_ok_s;
              bid_q      <= awid_q;
              bresp_q    <= werr_d ? RESP_SLVERR : burst_resp(wburst_q);
              werr_q     <= 1'b0;
            end else begin
              wcnt_q   <= wcnt_q + 8'd1;
              werr_q   <= werr_d;
              wready_q <= rdy_ok_s;
            end
          end else begin
            wready_q <= rdy_ok_s;
          end
        end
        W_RESP: begin
          if (!bvalid_q) begin
            bvalid_q <= 1'b1;
          end else if (bready) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule
